niosqs_nios2_qsys_0_oci_dct_packer: RTL and testbench

Packs 2-bit debug-control-trace (DCT) codes from the Nios II OCI trace logic into 30-bit DCT buffers. Each buffer holds up to 15 codes and carries a 4-bit fill count. It exposes the live `dct_buffer`/`dct_count` pair consumed by the OCI test bench monitor. It also emits completed or flushed buffers as 34-bit frames to the trace FIFO over a valid/ready handshake. It sits between the OCI trace-code generator and the on-chip trace FIFO.

---
 rtl/niosqs_nios2_qsys_0_oci_dct_packer.sv | 114 +++++++++++
 tb/tb_niosqs_nios2_qsys_0_oci_dct_packer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/niosqs_nios2_qsys_0_oci_dct_packer.sv
// rtl/niosqs_nios2_qsys_0_oci_dct_packer.sv - packs 2-bit DCT trace codes into 30-bit buffers and 34-bit frames
module niosqs_nios2_qsys_0_oci_dct_packer #(
    parameter int IDLE_FLUSH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trc_on,
    input  logic        code_valid,
    input  logic [1:0]  code,
    input  logic        flush,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        frm_valid,
    output logic [33:0] frm_data,
    input  logic        frm_ready,
    output logic        overflow,
    input  logic        ovf_clr
);

    localparam logic [7:0] IDLE_LIMIT = 8'(IDLE_FLUSH);

    logic [7:0]  idle_cnt;
    logic        flush_pend;
    logic        trc_on_q;

    logic        frm_free;
    logic        full;
    logic        code_in;
    logic        fill_nf;
    logic        trc_fall;
    logic        idle_hit;
    logic        trigger;
    logic        has_data;
    logic        xfer;
    logic        accept;
    logic        drop;
    logic [29:0] shifted;
    logic [3:0]  count_inc;

    assign frm_free  = !frm_valid || frm_ready;
    assign full      = (dct_count == 4'd15);
    assign code_in   = trc_on && code_valid;
    assign fill_nf   = code_in && !full;
    assign trc_fall  = trc_on_q && !trc_on;
    assign idle_hit  = (idle_cnt >= IDLE_LIMIT);
    assign shifted   = {dct_buffer[27:0], code};
    assign count_inc = dct_count + 4'd1;

    // Count reaching 15 includes the cycle where the 15th code is accepted.
    assign trigger  = full || (fill_nf && (dct_count == 4'd14)) || flush || flush_pend
                      || idle_hit || trc_fall;
    assign has_data = (dct_count != 4'd0) || fill_nf;
    assign xfer     = frm_free && trigger && has_data;
    // A full buffer only takes a new code when it is being emptied this cycle.
    assign accept   = code_in && (!full || xfer);
    assign drop     = code_in && !accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            frm_valid  <= 1'b0;
            frm_data   <= '0;
            overflow   <= 1'b0;
            idle_cnt   <= '0;
            flush_pend <= 1'b0;
            trc_on_q   <= 1'b0;
        end else begin
            trc_on_q <= trc_on;

            if (xfer) begin
                frm_valid <= 1'b1;
                if (full)
                    frm_data <= {dct_count, dct_buffer};
                else if (fill_nf)
                    frm_data <= {count_inc, shifted};
                else
                    frm_data <= {dct_count, dct_buffer};

                if (accept && full) begin
                    dct_buffer <= {28'b0, code};
                    dct_count  <= 4'd1;
                end else begin
                    dct_buffer <= '0;
                    dct_count  <= '0;
                end
            end else begin
                if (frm_ready)
                    frm_valid <= 1'b0;
                if (accept) begin
                    dct_buffer <= shifted;
                    dct_count  <= count_inc;
                end
            end

            // Triggers that find nothing to send are discarded rather than held.
            if (xfer || (trigger && !has_data))
                flush_pend <= 1'b0;
            else if (trigger)
                flush_pend <= 1'b1;

            if (accept || xfer)
                idle_cnt <= '0;
            else if ((dct_count != 4'd0) && (idle_cnt != 8'hFF))
                idle_cnt <= idle_cnt + 8'd1;

            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_niosqs_nios2_qsys_0_oci_dct_packer.sv
// tb/tb_niosqs_nios2_qsys_0_oci_dct_packer.sv - scoreboard bench for the DCT packer
module tb_niosqs_nios2_qsys_0_oci_dct_packer;

    logic        clk;
    logic        reset_n;
    logic        trc_on;
    logic        code_valid;
    logic [1:0]  code;
    logic        flush;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frm_valid;
    logic [33:0] frm_data;
    logic        frm_ready;
    logic        overflow;
    logic        ovf_clr;

    int checks;
    int errors;
    int frames_seen;
    logic [33:0] exp_q[$];

    niosqs_nios2_qsys_0_oci_dct_packer #(.IDLE_FLUSH(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .trc_on     (trc_on),
        .code_valid (code_valid),
        .code       (code),
        .flush      (flush),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .frm_valid  (frm_valid),
        .frm_data   (frm_data),
        .frm_ready  (frm_ready),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake monitor: inputs are stable at the falling edge, so a
    // valid&&ready seen here is the transfer taken at the next rising edge.
    always @(negedge clk) begin
        if (reset_n && frm_valid && frm_ready) begin
            logic [33:0] exp_frame;
            frames_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame_unexpected got=%h", frm_data);
            end else begin
                exp_frame = exp_q.pop_front();
                if (frm_data !== exp_frame) begin
                    errors++;
                    $display("FAIL frame_data got=%h exp=%h", frm_data, exp_frame);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] c);
        code_valid = 1'b1;
        code       = c;
        tick();
        code_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (dct_buffer !== 30'd0 || dct_count !== 4'd0 || frm_valid !== 1'b0 ||
            frm_data !== 34'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got buf=%h cnt=%0d v=%b d=%h ovf=%b exp all zero",
                     dct_buffer, dct_count, frm_valid, frm_data, overflow);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        frm_ready = 1'b1;
        for (int i = 0; i < 14; i++) send(2'((i + 1) % 4));
        checks++;
        if (dct_count !== 4'd14 || frm_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_fill got cnt=%0d v=%b exp cnt=14 v=0", dct_count, frm_valid);
        end
        exp_q.push_back({4'hF, 30'h1B1B1B1B});
        send(2'd3);
        checks++;
        if (frm_valid !== 1'b1 || frm_data !== {4'hF, 30'h1B1B1B1B} || dct_count !== 4'd0) begin
            errors++;
            $display("FAIL b2b_frame got v=%b d=%h cnt=%0d exp v=1 d=%h cnt=0",
                     frm_valid, frm_data, dct_count, {4'hF, 30'h1B1B1B1B});
        end
        tick();
        checks++;
        if (frm_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_one_cycle got v=%b exp 0", frm_valid);
        end
    endtask

    task automatic test_partial_flush();
        int seen0;
        logic [33:0] exp_frame;
        exp_frame = {4'd3, 24'b0, 2'b11, 2'b01, 2'b10};
        send(2'd3);
        send(2'd1);
        send(2'd2);
        exp_q.push_back(exp_frame);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (frm_valid !== 1'b1 || frm_data !== exp_frame || dct_count !== 4'd0 ||
            dct_buffer !== 30'd0) begin
            errors++;
            $display("FAIL partial_flush got v=%b d=%h cnt=%0d buf=%h exp v=1 d=%h empty",
                     frm_valid, frm_data, dct_count, dct_buffer, exp_frame);
        end
        tick();
        seen0 = frames_seen;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        checks++;
        if (frm_valid !== 1'b0 || frames_seen != seen0) begin
            errors++;
            $display("FAIL empty_flush got v=%b frames=%0d exp v=0 frames=%0d",
                     frm_valid, frames_seen, seen0);
        end
    endtask

    task automatic test_overflow();
        logic [29:0] b1, b2;
        logic [1:0]  c;
        logic [1:0]  c32;
        logic [33:0] f1, f2, f3;
        b1 = '0;
        b2 = '0;
        frm_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            c  = 2'($urandom_range(0, 3));
            b1 = {b1[27:0], c};
            send(c);
        end
        f1 = {4'hF, b1};
        checks++;
        if (frm_valid !== 1'b1 || frm_data !== f1) begin
            errors++;
            $display("FAIL ovf_first_frame got v=%b d=%h exp v=1 d=%h", frm_valid, frm_data, f1);
        end
        for (int i = 0; i < 15; i++) begin
            c  = 2'($urandom_range(0, 3));
            b2 = {b2[27:0], c};
            send(c);
        end
        checks++;
        if (overflow !== 1'b0 || dct_count !== 4'd15) begin
            errors++;
            $display("FAIL ovf_before_drop got ovf=%b cnt=%0d exp ovf=0 cnt=15", overflow, dct_count);
        end
        send(2'($urandom_range(0, 3)));
        checks++;
        if (overflow !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== b2 || frm_data !== f1) begin
            errors++;
            $display("FAIL ovf_after_drop got ovf=%b cnt=%0d buf=%h d=%h exp ovf=1 cnt=15 buf=%h d=%h",
                     overflow, dct_count, dct_buffer, frm_data, b2, f1);
        end
        f2  = {4'hF, b2};
        c32 = 2'($urandom_range(0, 3));
        exp_q.push_back(f1);
        frm_ready  = 1'b1;
        code_valid = 1'b1;
        code       = c32;
        tick();
        frm_ready  = 1'b0;
        code_valid = 1'b0;
        checks++;
        if (frm_valid !== 1'b1 || frm_data !== f2 || dct_count !== 4'd1 ||
            dct_buffer !== {28'b0, c32}) begin
            errors++;
            $display("FAIL ovf_second_frame got v=%b d=%h cnt=%0d buf=%h exp v=1 d=%h cnt=1 buf=%h",
                     frm_valid, frm_data, dct_count, dct_buffer, f2, {28'b0, c32});
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b exp 0", overflow);
        end
        exp_q.push_back(f2);
        frm_ready = 1'b1;
        tick();
        f3 = {4'd1, 28'b0, c32};
        exp_q.push_back(f3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        checks++;
        if (frm_valid !== 1'b0 || dct_count !== 4'd0) begin
            errors++;
            $display("FAIL ovf_drain got v=%b cnt=%0d exp v=0 cnt=0", frm_valid, dct_count);
        end
    endtask

    task automatic test_idle_flush();
        int hit;
        logic [1:0] a, b;
        a = 2'($urandom_range(0, 3));
        b = 2'($urandom_range(0, 3));
        hit = 0;
        frm_ready = 1'b1;
        exp_q.push_back({4'd2, 26'b0, a, b});
        send(a);
        send(b);
        for (int k = 1; k <= 25 && hit == 0; k++) begin
            tick();
            if (frm_valid === 1'b1) hit = k;
        end
        checks++;
        if (hit != 17) begin
            errors++;
            $display("FAIL idle_latency got %0d cycles exp 17", hit);
        end
        tick();
    endtask

    task automatic test_code_flush_trc_fall();
        logic [29:0] b;
        logic [1:0]  c;
        int seen0;
        frm_ready = 1'b1;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            c = 2'($urandom_range(0, 3));
            b = {b[27:0], c};
            send(c);
        end
        c = 2'($urandom_range(0, 3));
        b = {b[27:0], c};
        exp_q.push_back({4'd5, b});
        flush = 1'b1;
        send(c);
        flush = 1'b0;
        checks++;
        if (frm_valid !== 1'b1 || frm_data[33:30] !== 4'd5 || dct_count !== 4'd0) begin
            errors++;
            $display("FAIL code_with_flush got v=%b cnt_f=%0d cnt=%0d exp v=1 cnt_f=5 cnt=0",
                     frm_valid, frm_data[33:30], dct_count);
        end
        tick();
        b = '0;
        for (int i = 0; i < 3; i++) begin
            c = 2'($urandom_range(0, 3));
            b = {b[27:0], c};
            send(c);
        end
        exp_q.push_back({4'd3, b});
        trc_on     = 1'b0;
        code_valid = 1'b1;
        code       = 2'd2;
        tick();
        checks++;
        if (frm_valid !== 1'b1 || frm_data[33:30] !== 4'd3 || dct_count !== 4'd0) begin
            errors++;
            $display("FAIL trc_fall got v=%b cnt_f=%0d cnt=%0d exp v=1 cnt_f=3 cnt=0",
                     frm_valid, frm_data[33:30], dct_count);
        end
        tick();
        seen0 = frames_seen;
        repeat (3) tick();
        code_valid = 1'b0;
        checks++;
        if (dct_count !== 4'd0 || frames_seen != seen0) begin
            errors++;
            $display("FAIL trc_off_ignore got cnt=%0d frames=%0d exp cnt=0 frames=%0d",
                     dct_count, frames_seen, seen0);
        end
        trc_on = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [1:0] a, b;
        frm_ready = 1'b0;
        for (int i = 0; i < 22; i++) send(2'($urandom_range(0, 3)));
        checks++;
        if (frm_valid !== 1'b1 || dct_count !== 4'd7) begin
            errors++;
            $display("FAIL rst_mid_setup got v=%b cnt=%0d exp v=1 cnt=7", frm_valid, dct_count);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (dct_buffer !== 30'd0 || dct_count !== 4'd0 || frm_valid !== 1'b0 ||
            frm_data !== 34'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_async got buf=%h cnt=%0d v=%b d=%h ovf=%b exp all zero",
                     dct_buffer, dct_count, frm_valid, frm_data, overflow);
        end
        repeat (2) tick();
        reset_n   = 1'b1;
        frm_ready = 1'b1;
        tick();
        a = 2'($urandom_range(0, 3));
        b = 2'($urandom_range(0, 3));
        exp_q.push_back({4'd2, 26'b0, a, b});
        send(a);
        flush = 1'b1;
        send(b);
        flush = 1'b0;
        checks++;
        if (frm_valid !== 1'b1 || frm_data !== {4'd2, 26'b0, a, b}) begin
            errors++;
            $display("FAIL rst_first_frame got v=%b d=%h exp v=1 d=%h",
                     frm_valid, frm_data, {4'd2, 26'b0, a, b});
        end
        repeat (2) tick();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        frames_seen = 0;
        reset_n     = 1'b0;
        trc_on      = 1'b1;
        code_valid  = 1'b0;
        code        = 2'd0;
        flush       = 1'b0;
        frm_ready   = 1'b0;
        ovf_clr     = 1'b0;

        test_reset();
        test_back_to_back();
        test_partial_flush();
        test_overflow();
        test_idle_flush();
        test_code_flush_trc_fall();
        test_reset_mid();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d frames left exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
